// File: rtl/vc_pause_scheduler_pkg.sv
// Shared flow-control definitions for the upstream VC pause scheduler.
// Holds the state encodings, the VC count and the default payload width.
package vc_pause_scheduler_pkg;

   localparam int NUM_VC         = 4;
   localparam int VC_W           = 2;
   localparam int DEF_DATA_WIDTH = 6;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } sched_state_t;

endpackage

// File: rtl/vc_pause_scheduler_rr_arbiter4.sv
// Four-way round-robin arbiter: first eligible VC at or after ptr, wrapping 3->0.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter4
   import vc_pause_scheduler_pkg::*;
(
   input  logic [NUM_VC-1:0] eligible,
   input  logic [VC_W-1:0]   ptr,
   output logic [NUM_VC-1:0] grant,
   output logic [VC_W-1:0]   grant_idx,
   output logic              any_grant
);

   logic [VC_W-1:0] idx;

   // Scan from the farthest offset down so the nearest eligible VC wins last.
   always_comb begin
      idx       = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      for (int k = NUM_VC - 1; k >= 0; k--) begin
         idx = ptr + VC_W'(k);
         if (eligible[idx]) begin
            grant_idx = idx;
            any_grant = 1'b1;
         end
      end
      grant = any_grant ? (NUM_VC'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/vc_pause_scheduler.sv
// Upstream VC pause scheduler: tracks per-VC pause state from downstream strobes,
// round-robin pops the source FIFOs onto the shared link and flags long pauses.
//
// state  | meaning
// RESET  | just out of reset, strobes ignored
// INIT   | waiting for downstream init_done
// IDLE   | ready, nothing to send or link busy
// ACTIVE | popping one eligible VC per cycle
module vc_pause_scheduler
   import vc_pause_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int PAUSE_TIMEOUT = 64,
   parameter int TO_WIDTH      = 7
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         init_done,
   input  logic [NUM_VC-1:0]            pause_stb,
   input  logic [NUM_VC-1:0]            continue_stb,
   input  logic [NUM_VC-1:0]            src_empty,
   input  logic [NUM_VC*DATA_WIDTH-1:0] src_data,
   input  logic                         link_busy,
   output logic [NUM_VC-1:0]            pop,
   output logic                         out_valid,
   output logic [VC_W-1:0]              out_vc,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [NUM_VC-1:0]            paused,
   output logic [NUM_VC-1:0]            error_pause,
   output logic [1:0]                   state
);

   localparam logic [TO_WIDTH-1:0] TO_MAX  = TO_WIDTH'(PAUSE_TIMEOUT);
   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(PAUSE_TIMEOUT - 1);

   sched_state_t          st_q, st_d;
   logic [NUM_VC-1:0]     paused_q, paused_d;
   logic [NUM_VC-1:0]     eligible;
   logic [NUM_VC-1:0]     grant;
   logic [VC_W-1:0]       grant_idx;
   logic                  any_grant;
   logic [VC_W-1:0]       rr_q;
   logic [TO_WIDTH-1:0]   pause_cnt [NUM_VC];

   // Pause dominates continue when both arrive together.
   always_comb begin
      paused_d = paused_q;
      if (st_q != ST_RESET) paused_d = pause_stb | (paused_q & ~continue_stb);
   end

   assign eligible = ~src_empty & ~paused_d;

   rr_arbiter4 u_arb (
      .eligible  (eligible),
      .ptr       (rr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   assign pop = (st_q == ST_ACTIVE && !link_busy && !reset) ? grant : '0;

   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_RESET:  st_d = ST_INIT;
         ST_INIT:   if (init_done) st_d = ST_IDLE;
         ST_IDLE: begin
            if (!init_done)                    st_d = ST_INIT;
            else if (any_grant && !link_busy)  st_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (!init_done)                    st_d = ST_INIT;
            else if (!any_grant || link_busy)  st_d = ST_IDLE;
         end
         default:   st_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q        <= ST_RESET;
         paused_q    <= '0;
         rr_q        <= '0;
         out_valid   <= 1'b0;
         out_vc      <= '0;
         error_pause <= '0;
         for (int i = 0; i < NUM_VC; i++) pause_cnt[i] <= '0;
      end else begin
         st_q      <= st_d;
         paused_q  <= paused_d;
         out_valid <= |pop;
         if (|pop) begin
            rr_q   <= grant_idx + VC_W'(1);
            out_vc <= grant_idx;
         end
         for (int i = 0; i < NUM_VC; i++) begin
            if (paused_q[i]) begin
               if (pause_cnt[i] < TO_MAX)   pause_cnt[i] <= pause_cnt[i] + TO_WIDTH'(1);
               if (pause_cnt[i] >= TO_LAST) error_pause[i] <= 1'b1;
            end else begin
               pause_cnt[i] <= '0;
            end
         end
      end
   end

   assign out_data = src_data[int'(out_vc)*DATA_WIDTH +: DATA_WIDTH];
   assign paused   = paused_q;
   assign state    = st_q;

endmodule
